fir_sequencer: RTL and testbench
================================

// Module: fir_sequencer
// PURPOSE
//  Microsequencer for the 16x16 register-file FIR datapath: issues op/src1/src2/dest each cycle.
//  Loads NUM_TAPS coefficients, shifts the sample delay line, and runs the multiply-accumulate chain.
//  Sits between the AHB slave front end and the datapath; status feeds the sample counter and the slave.
// PARAMETERS
//  NUM_TAPS  4  filter taps, legal 1..7
//    Register map: R0 accumulator, R1 product temp, R2..R(1+N) samples (R2 newest), R(2+N).. coeffs
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous, active-high reset
//  data_ready     in   1   new sample present on datapath ext_data1 (level; rising edge = request)
//  load_coeff     in   1   request coefficient load (level, sampled in IDLE)
//  coeff_valid    in   1   coefficient word present on datapath ext_data2
//  overflow       in   1   datapath arithmetic overflow, valid in the cycle of the op
//  op             out  3   0 NOP, 1 COPY, 2 LOAD1, 3 LOAD2, 4 ADD, 5 SUB, 6 MUL
//  src1,src2,dest out  4   register-file indices
//  coeff_ack      out  1   coefficient word consumed this cycle
//  modwait        out  1   busy (not IDLE)
//  processed      out  1   one-cycle pulse: result in R0
//  cnt_up         out  1   one-cycle pulse coincident with processed
//  err            out  1   sticky error flag
// BEHAVIOUR
//  Reset: state IDLE, op=NOP, src/dest=0, all 1-bit outputs 0, tap index 0, pending 0.
//    Edge-detect register cleared to 0.
//  Reset mid-sequence aborts in the same edge; no partial writes after reset.
//  Outputs are Moore-decoded from state and tap index; the datapath writes on the next edge.
//  IDLE: load_coeff=1 -> COEFF; load_coeff wins over a simultaneous sample request.
//    Else sample request (new edge or pending) -> SHIFT; pending cleared.
//  COEFF: tap j from 0; coeff_valid=0 -> op NOP, wait.
//    coeff_valid=1 -> LOAD2 dest=R(2+N+j), coeff_ack=1, j++.
//    After j=N-1 -> IDLE.
//  SHIFT: i=N-1 down to 1, COPY dest=R(2+i) src1=R(1+i), N-1 cycles; skipped when N=1.
//  LOADS: LOAD1 dest=R2.
//  MUL0: MUL dest=R0 src1=R2 src2=R(2+N).
//  MULi/ADDi, i=1..N-1:
//    MUL dest=R1 src1=R(2+i) src2=R(2+N+i).
//    Then ADD dest=R0 src1=R0 src2=R1.
//  DONE: processed=cnt_up=1, op NOP -> IDLE.
//  Latency: processed high 3N cycles after the cycle the data_ready edge is seen in IDLE (N=4: 12).
//  Rising edge of data_ready while modwait=1 sets pending (one-deep).
//    An edge with pending already set is dropped and sets err.
//  overflow=1 during any MUL/ADD cycle sets err next edge; the sequence still completes to DONE.
//  err clears on entering SHIFT for a new sample; a set in the same cycle wins.
//  Coefficient registers retain values across samples; reset does not clear the datapath.
// STRUCTURE
//  fir_pkg: op_t enum (NOP..MUL), state_t enum.
//    REG_ACC=0, REG_TMP=1, REG_SAMPLE0=2; a function coeff_reg(N,j).
//  Sub-module rise_detect: 1-flop rising-edge detector on data_ready, synchronous active-high reset.
//  The FSM and tap counter ($clog2(NUM_TAPS)+1 bits) are kept in fir_sequencer.
// TESTING
//  Coeff load: N=4, coeff_valid for 4 cycles with gaps.
//    -> exactly 4 LOAD2 to R6..R9, 4 coeff_ack pulses, then IDLE.
//  Sample: coeffs 1,2,3,4; samples 10,20,30,40.
//    -> after the 4th, R0=40*1+30*2+20*3+10*4=200.
//    -> processed 12 cycles after the edge, cnt_up coincident.
//  Back-to-back: second data_ready edge mid-MAC -> pending.
//    -> SHIFT starts the cycle after DONE, no err.
//  Third edge while pending -> err=1, sample dropped; err clears at the next SHIFT entry.
//  Overflow forced on an ADD cycle -> err=1 next cycle, processed still pulses at cycle 12.
//  rst asserted in the MULi state -> next cycle op=NOP, modwait=0, all pulses 0, IDLE.
//    data_ready must show a fresh edge to restart.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and register-map helpers for the FIR microsequencer.
// The register file holds the accumulator, a product temp, the sample
// delay line (newest sample in R2) and then the coefficient bank.
package fir_pkg;

    // Datapath operation codes issued each cycle.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_COPY  = 3'd1,
        OP_LOAD1 = 3'd2,
        OP_LOAD2 = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_MUL   = 3'd6
    } op_t;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COEFF,
        ST_SHIFT,
        ST_LOADS,
        ST_MUL0,
        ST_MULI,
        ST_ADDI,
        ST_DONE
    } state_t;

    localparam logic [3:0] REG_ACC     = 4'd0;
    localparam logic [3:0] REG_TMP     = 4'd1;
    localparam logic [3:0] REG_SAMPLE0 = 4'd2;

    // Register holding delay-line tap i (i = 0 is the newest sample).
    function automatic logic [3:0] sample_reg(input int i);
        return 4'(int'(REG_SAMPLE0) + i);
    endfunction

    // Register holding coefficient j for an n-tap filter.
    function automatic logic [3:0] coeff_reg(input int n, input int j);
        return 4'(int'(REG_SAMPLE0) + n + j);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-flop rising-edge detector. The history flop clears on reset, so a
// level that is still high when reset releases is seen as a new edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's level.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/fir_sequencer.sv
// Microsequencer for the 16x16 register-file FIR datapath. Loads the
// coefficient bank, shifts the sample delay line and runs the MAC chain,
// issuing one op/src1/src2/dest word per cycle. The datapath commits the
// issued op on the following clock edge.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 4   // legal 1..7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_ready,
    input  logic       load_coeff,
    input  logic       coeff_valid,
    input  logic       overflow,
    output op_t        op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       coeff_ack,
    output logic       modwait,
    output logic       processed,
    output logic       cnt_up,
    output logic       err
);

    localparam int              TW       = $clog2(NUM_TAPS) + 1;
    localparam logic [TW-1:0]   LAST_TAP = TW'(NUM_TAPS - 1);
    localparam logic [TW-1:0]   ONE_TAP  = TW'(1);

    state_t          state_q, state_d;
    logic [TW-1:0]   tap_q, tap_d;
    logic            pending_q, pending_d;
    logic            err_q, err_d;
    logic            data_rise;
    logic            start_sample;
    logic            queue_rise;
    logic            err_set;

    rise_detect u_rise (
        .clk    (clk),
        .rst    (rst),
        .d_i    (data_ready),
        .rise_o (data_rise)
    );

    // State, tap index, pending request and sticky error registers.
    // NOTE: reset is synchronous, so an assertion mid-sequence takes effect on the same edge that would have advanced the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // Next-state and tap-index sequencing.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        start_sample = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load_coeff) begin
                    state_d = ST_COEFF;
                    tap_d   = '0;
                end else if (data_rise || pending_q) begin
                    start_sample = 1'b1;
                end
            end
            ST_COEFF: begin
                if (coeff_valid) begin
                    if (tap_q == LAST_TAP) begin
                        state_d = ST_IDLE;
                        tap_d   = '0;
                    end else begin
                        tap_d = tap_q + ONE_TAP;
                    end
                end
            end
            ST_SHIFT: begin
                if (tap_q == ONE_TAP) state_d = ST_LOADS;
                else                  tap_d   = tap_q - ONE_TAP;
            end
            ST_LOADS: state_d = ST_MUL0;
            ST_MUL0: begin
                if (NUM_TAPS == 1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MULI;
                    tap_d   = ONE_TAP;
                end
            end
            ST_MULI: state_d = ST_ADDI;
            ST_ADDI: begin
                if (tap_q == LAST_TAP) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MULI;
                    tap_d   = tap_q + ONE_TAP;
                end
            end
            ST_DONE: begin
                // A queued sample starts straight away instead of idling a cycle.
                if (pending_q) start_sample = 1'b1;
                else           state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tap_d   = '0;
            end
        endcase

        // A single-tap filter has no delay line to shift.
        if (start_sample) begin
            if (NUM_TAPS > 1) begin
                state_d = ST_SHIFT;
                tap_d   = LAST_TAP;
            end else begin
                state_d = ST_LOADS;
                tap_d   = '0;
            end
        end
    end

    // One-deep request queue and sticky error bookkeeping.
    always_comb begin
        pending_d = pending_q;
        err_set   = 1'b0;
        // A rise that cannot start a sample now must be queued: busy, or
        // coefficient loading taking priority in IDLE.
        queue_rise = data_rise && ((state_q != ST_IDLE) || load_coeff);

        if (start_sample) pending_d = 1'b0;

        if (queue_rise) begin
            if (pending_q) err_set   = 1'b1;   // queue full: sample dropped
            else           pending_d = 1'b1;
        end else if (data_rise && pending_q && state_q == ST_IDLE) begin
            // IDLE serves the older queued request; the fresh rise takes its slot.
            pending_d = 1'b1;
        end

        if (overflow && (state_q inside {ST_MUL0, ST_MULI, ST_ADDI})) err_set = 1'b1;

        err_d = err_q;
        if (start_sample) err_d = 1'b0;
        if (err_set)      err_d = 1'b1;   // a set in the clearing cycle wins
    end

    // Moore decode of the datapath control word from state and tap index.
    always_comb begin
        op        = OP_NOP;
        src1      = '0;
        src2      = '0;
        dest      = '0;
        coeff_ack = 1'b0;
        processed = 1'b0;
        cnt_up    = 1'b0;
        modwait   = (state_q != ST_IDLE);

        unique case (state_q)
            ST_COEFF: begin
                if (coeff_valid) begin
                    op        = OP_LOAD2;
                    dest      = coeff_reg(NUM_TAPS, int'(tap_q));
                    coeff_ack = 1'b1;
                end
            end
            ST_SHIFT: begin
                op   = OP_COPY;
                dest = sample_reg(int'(tap_q));
                src1 = sample_reg(int'(tap_q) - 1);
            end
            ST_LOADS: begin
                op   = OP_LOAD1;
                dest = REG_SAMPLE0;
            end
            ST_MUL0: begin
                op   = OP_MUL;
                dest = REG_ACC;
                src1 = sample_reg(0);
                src2 = coeff_reg(NUM_TAPS, 0);
            end
            ST_MULI: begin
                op   = OP_MUL;
                dest = REG_TMP;
                src1 = sample_reg(int'(tap_q));
                src2 = coeff_reg(NUM_TAPS, int'(tap_q));
            end
            ST_ADDI: begin
                op   = OP_ADD;
                dest = REG_ACC;
                src1 = REG_ACC;
                src2 = REG_TMP;
            end
            ST_DONE: begin
                processed = 1'b1;
                cnt_up    = 1'b1;
            end
            default: ;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer (NUM_TAPS = 4) with a behavioural
// register-file datapath so the accumulated result can be checked.
module tb_fir_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_ready;
    logic        load_coeff;
    logic        coeff_valid;
    logic        overflow;
    logic [2:0]  op;
    logic [3:0]  src1, src2, dest;
    logic        coeff_ack, modwait, processed, cnt_up, err;

    logic [15:0] ext1, ext2;
    logic [15:0] rf [16] = '{default: 16'd0};
    logic [31:0] trace_tab [1:11];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_sequencer #(.NUM_TAPS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_ready  (data_ready),
        .load_coeff  (load_coeff),
        .coeff_valid (coeff_valid),
        .overflow    (overflow),
        .op          (op),
        .src1        (src1),
        .src2        (src2),
        .dest        (dest),
        .coeff_ack   (coeff_ack),
        .modwait     (modwait),
        .processed   (processed),
        .cnt_up      (cnt_up),
        .err         (err)
    );

    // Datapath model: commits the issued op on the next edge.
    always @(posedge clk) begin
        case (op)
            3'd1:    rf[dest] <= rf[src1];
            3'd2:    rf[dest] <= ext1;
            3'd3:    rf[dest] <= ext2;
            3'd4:    rf[dest] <= rf[src1] + rf[src2];
            3'd5:    rf[dest] <= rf[src1] - rf[src2];
            3'd6:    rf[dest] <= rf[src1] * rf[src2];
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input int o, input int d, input int s1, input int s2);
        return 32'((o << 12) | (d << 8) | (s1 << 4) | s2);
    endfunction

    function automatic logic [31:0] obs_ins();
        return 32'({op, dest, src1, src2});
    endfunction

    function automatic logic [31:0] obs_flags();
        return 32'({coeff_ack, modwait, processed, cnt_up, err});
    endfunction

    // One sample from IDLE: edge in c0, processed expected in c12, IDLE in c13.
    task automatic run_sample(input string tag, input logic [15:0] v,
                              input logic [15:0] exp_r0, input bit trace);
        tick();
        ext1       = v;
        data_ready = 1'b1;
        #1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1) data_ready = 1'b0;
            #1;
            if (trace && k <= 11) check($sformatf("%s op c%0d", tag, k), obs_ins(), trace_tab[k]);
            if (k == 11) check({tag, " processed early"}, 32'(processed), 32'd0);
            if (k == 12) begin
                check({tag, " processed"}, 32'(processed), 32'd1);
                check({tag, " cnt_up"}, 32'(cnt_up), 32'd1);
                check({tag, " R0"}, 32'(rf[0]), 32'(exp_r0));
            end
            if (k == 13) check({tag, " back to idle"}, 32'(modwait), 32'd0);
        end
    endtask

    initial begin
        logic [6:0] vld_pat;
        int j;
        int acks;

        trace_tab[1]  = ins(1, 5, 4, 0);
        trace_tab[2]  = ins(1, 4, 3, 0);
        trace_tab[3]  = ins(1, 3, 2, 0);
        trace_tab[4]  = ins(2, 2, 0, 0);
        trace_tab[5]  = ins(6, 0, 2, 6);
        trace_tab[6]  = ins(6, 1, 3, 7);
        trace_tab[7]  = ins(4, 0, 0, 1);
        trace_tab[8]  = ins(6, 1, 4, 8);
        trace_tab[9]  = ins(4, 0, 0, 1);
        trace_tab[10] = ins(6, 1, 5, 9);
        trace_tab[11] = ins(4, 0, 0, 1);

        rst = 1'b1; data_ready = 1'b0; load_coeff = 1'b0;
        coeff_valid = 1'b0; overflow = 1'b0; ext1 = '0; ext2 = '0;

        // Reset state.
        tick();
        tick();
        check("reset ins", obs_ins(), 32'd0);
        check("reset flags", obs_flags(), 32'd0);
        rst = 1'b0;
        tick();
        check("idle ins", obs_ins(), 32'd0);
        check("idle flags", obs_flags(), 32'd0);

        // Coefficient load with gaps: 1,2,3,4 into R6..R9.
        tick();
        load_coeff = 1'b1;
        #1;
        check("coeff c0 idle", 32'(modwait), 32'd0);
        vld_pat = 7'b1001101;
        j = 0;
        acks = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            load_coeff  = 1'b0;
            coeff_valid = vld_pat[k-1];
            ext2        = 16'(j + 1);
            #1;
            if (vld_pat[k-1]) check($sformatf("coeff ins c%0d", k), obs_ins(), ins(3, 6 + j, 0, 0));
            else              check($sformatf("coeff ins c%0d", k), obs_ins(), 32'd0);
            check($sformatf("coeff ack c%0d", k), 32'(coeff_ack), 32'(vld_pat[k-1]));
            check($sformatf("coeff busy c%0d", k), 32'(modwait), 32'd1);
            acks += int'(coeff_ack);
            if (vld_pat[k-1]) j++;
        end
        tick();
        coeff_valid = 1'b0;
        #1;
        check("coeff ack count", 32'(acks), 32'd4);
        check("coeff done idle", 32'(modwait), 32'd0);
        check("coeff R6..R9", {rf[6][7:0], rf[7][7:0], rf[8][7:0], rf[9][7:0]}, 32'h01020304);

        // Samples 10,20,30,40; first one with a full op trace.
        run_sample("s10", 16'd10, 16'd10, 1'b1);
        run_sample("s20", 16'd20, 16'd40, 1'b0);
        run_sample("s30", 16'd30, 16'd100, 1'b0);
        run_sample("s40", 16'd40, 16'd200, 1'b0);

        // Back-to-back: second edge mid-MAC is queued.
        tick();
        ext1 = 16'd50; data_ready = 1'b1;
        #1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 1) data_ready = 1'b0;
            if (k == 6) begin ext1 = 16'd60; data_ready = 1'b1; end
            if (k == 7) data_ready = 1'b0;
            #1;
            if (k == 12) begin
                check("b2b first processed", 32'(processed), 32'd1);
                check("b2b first R0", 32'(rf[0]), 32'd300);
                check("b2b err at done", 32'(err), 32'd0);
            end
            if (k == 13) begin
                check("b2b shift after done", obs_ins(), ins(1, 5, 4, 0));
                check("b2b err at shift", 32'(err), 32'd0);
            end
            if (k == 24) begin
                check("b2b second processed", 32'(processed), 32'd1);
                check("b2b second R0", 32'(rf[0]), 32'd400);
            end
            if (k == 25) check("b2b idle", 32'(modwait), 32'd0);
        end

        // Third edge while one is pending: dropped, err set, cleared at next SHIFT.
        tick();
        ext1 = 16'd70; data_ready = 1'b1;
        #1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 1) data_ready = 1'b0;
            if (k == 6) begin ext1 = 16'd80; data_ready = 1'b1; end
            if (k == 7) data_ready = 1'b0;
            if (k == 8) data_ready = 1'b1;
            if (k == 9) data_ready = 1'b0;
            #1;
            if (k == 8) check("drop err before", 32'(err), 32'd0);
            if (k == 9) check("drop err set", 32'(err), 32'd1);
            if (k == 12) begin
                check("drop first R0", 32'(rf[0]), 32'd500);
                check("drop err sticky", 32'(err), 32'd1);
            end
            if (k == 13) check("drop err cleared at shift", 32'(err), 32'd0);
            if (k == 24) check("drop second R0", 32'(rf[0]), 32'd600);
            if (k == 26) check("drop no third run", 32'(modwait), 32'd0);
        end

        // Overflow on an ADD cycle.
        tick();
        ext1 = 16'd100; data_ready = 1'b1;
        #1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1) data_ready = 1'b0;
            if (k == 7) overflow = 1'b1;
            if (k == 8) overflow = 1'b0;
            #1;
            if (k == 7) begin
                check("ovf on add ins", obs_ins(), ins(4, 0, 0, 1));
                check("ovf err before", 32'(err), 32'd0);
            end
            if (k == 8) check("ovf err set", 32'(err), 32'd1);
            if (k == 12) begin
                check("ovf processed", 32'(processed), 32'd1);
                check("ovf cnt_up", 32'(cnt_up), 32'd1);
                check("ovf R0", 32'(rf[0]), 32'd710);
            end
            if (k == 13) check("ovf err sticky", 32'(err), 32'd1);
        end

        // Reset in MULi with a request queued: abort, nothing restarts.
        tick();
        ext1 = 16'd110; data_ready = 1'b1;
        #1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1) data_ready = 1'b0;
            if (k == 6) data_ready = 1'b1;
            if (k == 7) data_ready = 1'b0;
            if (k == 8) rst = 1'b1;
            if (k == 9) rst = 1'b0;
            #1;
            if (k == 1) check("rst err cleared at shift", 32'(err), 32'd0);
            if (k == 8) check("rst in muli", obs_ins(), ins(6, 1, 4, 8));
            if (k == 9) begin
                check("rst abort ins", obs_ins(), 32'd0);
                check("rst abort flags", obs_flags(), 32'd0);
            end
            if (k >= 10) check($sformatf("rst stays idle c%0d", k), 32'(modwait), 32'd0);
        end

        // Fresh edge restarts normally.
        run_sample("s120", 16'd120, 16'd960, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
